// File: rtl/logic_op_issuer.sv
// logic_op_issuer: buffers logical-unit commands in a small FIFO and issues
// them one at a time to an external combinational logical unit, capturing
// each result and holding it until the consumer accepts it.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds cmd_* stable while cmd_valid is high and
// cmd_ready is low. This block holds res_* stable while res_valid is high and
// res_ready is low.
//
// Optional feature: define LOGIC_ISSUER_PARITY_EN to add the res_parity
// output, the XOR-reduction of the captured result.
module logic_op_issuer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [2:0]       lu_sel,
    output logic [WIDTH-1:0] lu_a,
    output logic [WIDTH-1:0] lu_b,
    input  logic [WIDTH-1:0] lu_fout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [2:0]       res_op,
    output logic             busy,
    output logic [1:0]       dbg_state
`ifdef LOGIC_ISSUER_PARITY_EN
    ,
    output logic             res_parity
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t           r_state;
    logic [2:0]       r_op_mem [DEPTH];
    logic [WIDTH-1:0] r_a_mem  [DEPTH];
    logic [WIDTH-1:0] r_b_mem  [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             r_rdy_en;
    logic [2:0]       r_lu_sel;
    logic [WIDTH-1:0] r_lu_a;
    logic [WIDTH-1:0] r_lu_b;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_data;
    logic [2:0]       r_res_op;
    logic             r_parity;

    logic w_push;
    logic w_pop;
    logic w_not_empty;

    // cmd_ready is gated by r_rdy_en so it stays low during reset and rises
    // on the first edge after release; a same-cycle pop never raises it.
    assign w_not_empty = (r_count != '0);
    assign cmd_ready   = r_rdy_en && (r_count < (PW+1)'(DEPTH));
    assign w_push      = cmd_valid && cmd_ready;
    assign w_pop       = w_not_empty &&
                         ((r_state == S_IDLE) || ((r_state == S_RESP) && res_ready));

    assign lu_sel    = r_lu_sel;
    assign lu_a      = r_lu_a;
    assign lu_b      = r_lu_b;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_op    = r_res_op;
    assign busy      = (r_state != S_IDLE) || w_not_empty;
    assign dbg_state = r_state;
`ifdef LOGIC_ISSUER_PARITY_EN
    assign res_parity = r_parity;
`endif

    // FIFO storage: data only, validity is tracked by pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_op_mem[r_wr_ptr] <= cmd_op;
            r_a_mem[r_wr_ptr]  <= cmd_a;
            r_b_mem[r_wr_ptr]  <= cmd_b;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue FSM: load head into lu_*, capture lu_fout one cycle later, hold until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_lu_sel    <= '0;
            r_lu_a      <= '0;
            r_lu_b      <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_op    <= '0;
            r_parity    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_not_empty) begin
                        r_lu_sel <= r_op_mem[r_rd_ptr];
                        r_lu_a   <= r_a_mem[r_rd_ptr];
                        r_lu_b   <= r_b_mem[r_rd_ptr];
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_res_data  <= lu_fout;
                    r_res_op    <= r_lu_sel;
                    r_parity    <= ^lu_fout;
                    r_res_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (res_ready) begin
                        // The accepted result must not be presented again.
                        r_res_valid <= 1'b0;
                        if (w_not_empty) begin
                            r_lu_sel <= r_op_mem[r_rd_ptr];
                            r_lu_a   <= r_a_mem[r_rd_ptr];
                            r_lu_b   <= r_b_mem[r_rd_ptr];
                            r_state  <= S_ISSUE;
                        end else begin
                            r_state  <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
